umac_seq_ctrl: RTL

Sequencer for one 16-lane bipolar unary MAC (16 bipolar unary multipliers feeding a scaled unary adder). It accepts a job of sixteen 8-bit weights over a valid/ready handshake and pulses the MAC's weight load. It enables the input stream sources for a fixed window, counts ones on the MAC output bitstream, and returns a signed binary bipolar result over a second valid/ready handshake. It sits between the binary host/datapath side and the unary MAC array.

---
 rtl/umac_pkg.sv | 19 +
 rtl/umac_win_cnt.sv | 39 +++
 rtl/umac_seq_ctrl.sv | 100 ++++++++++
 3 files changed

// File: rtl/umac_pkg.sv
// Shared definitions for the unary MAC sequencer.
//   umac_state_t : controller state encoding (also driven onto the debug port)
//   DEF_*        : default window length, pipeline latency, weight width, lane count
package umac_pkg;

  localparam int DEF_LEN_LOG2 = 8;
  localparam int DEF_PIPE_LAT = 2;
  localparam int DEF_WB       = 8;
  localparam int DEF_LANES    = 16;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    FLUSH = 3'd2,
    RUN   = 3'd3,
    HOLD  = 3'd4
  } umac_state_t;

endpackage

// File: rtl/umac_win_cnt.sv
// Window and ones counter for the MAC output bitstream.
//   clk, rst_n : clock, synchronous active-low reset
//   clr        : zero both counters (takes priority over en)
//   en         : count this cycle: window += 1, ones += bit_in
//   bit_in     : MAC output bit
//   last       : window counter sits on the final sample index (N-1)
//   ones       : number of ones counted so far (0..N, never wraps)
module umac_win_cnt #(
  parameter int LEN_LOG2 = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              en,
  input  logic              bit_in,
  output logic              last,
  output logic [LEN_LOG2:0] ones
);

  // N-1 written as a bit pattern so it is exactly LEN_LOG2+1 bits wide.
  localparam logic [LEN_LOG2:0] LAST_IDX = {1'b0, {LEN_LOG2{1'b1}}};

  logic [LEN_LOG2:0] wcnt;
  logic [LEN_LOG2:0] ocnt;

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      wcnt <= '0;
      ocnt <= '0;
    end else if (en) begin
      wcnt <= wcnt + 1'b1;
      ocnt <= ocnt + {{LEN_LOG2{1'b0}}, bit_in};
    end
  end

  assign last = (wcnt == LAST_IDX);
  assign ones = ocnt;

endmodule

// File: rtl/umac_seq_ctrl.sv
// Sequencer for one multi-lane bipolar unary MAC.
// Accepts a weight job, pulses the MAC weight load, enables the stream
// sources for PIPE_LAT discarded cycles plus an N = 2^LEN_LOG2 counted
// window, and returns 2*ones - N as a signed result.
//   job_valid/job_ready/job_w : weight job input (lane i at [i*WB +: WB])
//   mac_iB, mac_loadB         : registered weights and one-cycle load strobe
//   src_en                    : stream generator / MAC RNG enable
//   mac_oC                    : MAC output bitstream
//   res_valid/res_ready/res_data : signed result output
//   busy                      : controller is not idle
//   dbg_state                 : current controller state
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both 1. The sender keeps valid and its data stable until that edge;
// ready never depends on valid, so the two sides cannot deadlock.
module umac_seq_ctrl
  import umac_pkg::*;
#(
  parameter int LEN_LOG2 = DEF_LEN_LOG2,
  parameter int PIPE_LAT = DEF_PIPE_LAT,
  parameter int WB       = DEF_WB,
  parameter int LANES    = DEF_LANES
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       job_valid,
  output logic                       job_ready,
  input  logic [LANES*WB-1:0]        job_w,
  output logic [LANES*WB-1:0]        mac_iB,
  output logic                       mac_loadB,
  output logic                       src_en,
  input  logic                       mac_oC,
  output logic                       res_valid,
  input  logic                       res_ready,
  output logic signed [LEN_LOG2+1:0] res_data,
  output logic                       busy,
  output logic [2:0]                 dbg_state
);

  localparam int FW = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;
  // N as a LEN_LOG2+2 bit positive value.
  localparam logic [LEN_LOG2+1:0] N_VAL = {2'b01, {LEN_LOG2{1'b0}}};

  umac_state_t       state;
  umac_state_t       state_nxt;
  logic [FW-1:0]     fcnt;
  logic              win_last;
  logic [LEN_LOG2:0] win_ones;
  logic [LANES*WB-1:0] w_reg;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (job_valid) state_nxt = LOAD;
      LOAD:    state_nxt = (PIPE_LAT == 0) ? RUN : FLUSH;
      FLUSH:   if (fcnt == FW'(PIPE_LAT - 1)) state_nxt = RUN;
      RUN:     if (win_last) state_nxt = HOLD;
      HOLD:    if (res_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      fcnt  <= '0;
      w_reg <= '0;
    end else begin
      state <= state_nxt;
      if (state == LOAD)  fcnt <= '0;
      else if (state == FLUSH) fcnt <= fcnt + 1'b1;
      // Weights change only on acceptance and are held afterwards.
      if (state == IDLE && job_valid) w_reg <= job_w;
    end
  end

  umac_win_cnt #(
    .LEN_LOG2(LEN_LOG2)
  ) u_win_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (state == LOAD),
    .en    (state == RUN),
    .bit_in(mac_oC),
    .last  (win_last),
    .ones  (win_ones)
  );

  // job_ready is masked by rst_n so it stays low for the whole reset period.
  assign job_ready = (state == IDLE) && rst_n;
  assign mac_iB    = w_reg;
  assign mac_loadB = (state == LOAD);
  assign src_en    = (state == FLUSH) || (state == RUN);
  assign res_valid = (state == HOLD);
  // Result shown only while offered, so the output rests at zero otherwise.
  assign res_data  = (state == HOLD) ? $signed({win_ones, 1'b0} - N_VAL) : '0;
  assign busy      = (state != IDLE);
  assign dbg_state = state;

endmodule
